// File: rtl/legv8_cpu.sv
// Single-cycle 64-bit LEGv8 core: one instruction per clock, combinational
// instruction and data memories outside the core, PC and X0..X30 as the only state.
module legv8_cpu #(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic [63:0] MEM_DATA_IN,
   output logic [63:0] PC,
   output logic [63:0] MEM_ADDRESS,
   output logic [63:0] MEM_DATA_OUT,
   output logic        MEM_WRITE,
   output logic        MEM_READ
);

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [5:0]  OPC_B    = 6'b000101;

   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
      OP_LDUR, OP_STUR, OP_CBZ, OP_B
   } op_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASS_B
   } alu_e;

   typedef enum logic [1:0] {
      SRC_REG, SRC_IMM12, SRC_DT9
   } src_e;

   // Instruction fields
   logic [4:0]  rd;
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic [11:0] imm12;
   logic [8:0]  dt9;
   logic [18:0] imm19;
   logic [25:0] imm26;

   assign rd    = INSTRUCTION[4:0];
   assign rn    = INSTRUCTION[9:5];
   assign rm    = INSTRUCTION[20:16];
   assign imm12 = INSTRUCTION[21:10];
   assign dt9   = INSTRUCTION[20:12];
   assign imm19 = INSTRUCTION[23:5];
   assign imm26 = INSTRUCTION[25:0];

   // Decode, widest opcode first so a longer match always wins
   op_e op;

   always_comb begin
      op = OP_NOP;
      case (INSTRUCTION[31:21])
         OPC_ADD:  op = OP_ADD;
         OPC_SUB:  op = OP_SUB;
         OPC_AND:  op = OP_AND;
         OPC_ORR:  op = OP_ORR;
         OPC_LDUR: op = OP_LDUR;
         OPC_STUR: op = OP_STUR;
         default: begin
            case (INSTRUCTION[31:22])
               OPC_ADDI: op = OP_ADDI;
               OPC_SUBI: op = OP_SUBI;
               default: begin
                  if (INSTRUCTION[31:24] == OPC_CBZ) begin
                     op = OP_CBZ;
                  end else if (INSTRUCTION[31:26] == OPC_B) begin
                     op = OP_B;
                  end
               end
            endcase
         end
      endcase
   end

   // Control signals
   logic reg2loc;
   logic reg_write;
   logic mem_to_reg;
   logic mem_read_ctl;
   logic mem_write_ctl;
   logic branch_cbz;
   logic branch_uncond;
   src_e alu_src;
   alu_e alu_ctl;

   always_comb begin
      reg2loc       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      mem_read_ctl  = 1'b0;
      mem_write_ctl = 1'b0;
      branch_cbz    = 1'b0;
      branch_uncond = 1'b0;
      alu_src       = SRC_REG;
      alu_ctl       = ALU_ADD;
      case (op)
         OP_ADD: begin
            reg_write = 1'b1;
         end
         OP_SUB: begin
            reg_write = 1'b1;
            alu_ctl   = ALU_SUB;
         end
         OP_AND: begin
            reg_write = 1'b1;
            alu_ctl   = ALU_AND;
         end
         OP_ORR: begin
            reg_write = 1'b1;
            alu_ctl   = ALU_ORR;
         end
         OP_ADDI: begin
            reg_write = 1'b1;
            alu_src   = SRC_IMM12;
         end
         OP_SUBI: begin
            reg_write = 1'b1;
            alu_src   = SRC_IMM12;
            alu_ctl   = ALU_SUB;
         end
         OP_LDUR: begin
            reg_write    = 1'b1;
            mem_to_reg   = 1'b1;
            mem_read_ctl = 1'b1;
            alu_src      = SRC_DT9;
         end
         OP_STUR: begin
            reg2loc       = 1'b1;
            mem_write_ctl = 1'b1;
            alu_src       = SRC_DT9;
         end
         OP_CBZ: begin
            reg2loc    = 1'b1;
            branch_cbz = 1'b1;
            alu_ctl    = ALU_PASS_B;
         end
         OP_B: begin
            branch_uncond = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Register file: X0..X30 as individual registers, X31 hardwired to zero
   logic [63:0] wb_data;
   logic [63:0] x_bank [0:31];

   generate
      for (genvar gi = 0; gi < 31; gi++) begin : gen_xreg
         logic [63:0] x_reg;

         always_ff @(posedge CLOCK) begin
            if (RESET) begin
               x_reg <= '0;
            end else if (reg_write && (rd == 5'(gi))) begin
               x_reg <= wb_data;
            end
         end

         assign x_bank[gi] = x_reg;
      end
   endgenerate

   assign x_bank[31] = '0;

   logic [4:0]  read_b_sel;
   logic [63:0] read_a;
   logic [63:0] read_b;

   assign read_b_sel = reg2loc ? rd : rm;
   assign read_a     = x_bank[rn];
   assign read_b     = x_bank[read_b_sel];

   // ALU
   logic [63:0] alu_b;
   logic [63:0] alu_result;

   always_comb begin
      alu_b = read_b;
      case (alu_src)
         SRC_IMM12: alu_b = {52'd0, imm12};
         SRC_DT9:   alu_b = {{55{dt9[8]}}, dt9};
         default:   alu_b = read_b;
      endcase
   end

   always_comb begin
      alu_result = read_a + alu_b;
      case (alu_ctl)
         ALU_SUB:    alu_result = read_a - alu_b;
         ALU_AND:    alu_result = read_a & alu_b;
         ALU_ORR:    alu_result = read_a | alu_b;
         ALU_PASS_B: alu_result = alu_b;
         default:    alu_result = read_a + alu_b;
      endcase
   end

   assign wb_data = mem_to_reg ? MEM_DATA_IN : alu_result;

   // Branch targets are relative to the branch instruction's own PC
   logic [63:0] pc_reg;
   logic [63:0] pc_next;
   logic [63:0] cbz_offset;
   logic [63:0] b_offset;

   assign cbz_offset = {{43{imm19[18]}}, imm19, 2'b00};
   assign b_offset   = {{36{imm26[25]}}, imm26, 2'b00};

   always_comb begin
      pc_next = pc_reg + 64'd4;
      if (branch_uncond) begin
         pc_next = pc_reg + b_offset;
      end else if (branch_cbz && (read_b == 64'd0)) begin
         pc_next = pc_reg + cbz_offset;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   assign PC           = pc_reg;
   assign MEM_ADDRESS  = alu_result;
   assign MEM_DATA_OUT = read_b;
   assign MEM_WRITE    = mem_write_ctl & ~RESET;
   assign MEM_READ     = mem_read_ctl & ~RESET;

endmodule

// File: tb/tb_legv8_cpu.sv
// Random and directed instruction streams for legv8_cpu, checked cycle by cycle
// against an instruction-level model of the architectural state.
module tb_legv8_cpu;

   localparam logic [63:0] RESET_PC = 64'd0;

   localparam logic [10:0] K_ADD  = 11'b10001011000;
   localparam logic [10:0] K_SUB  = 11'b11001011000;
   localparam logic [10:0] K_AND  = 11'b10001010000;
   localparam logic [10:0] K_ORR  = 11'b10101010000;
   localparam logic [10:0] K_LDUR = 11'b11111000010;
   localparam logic [10:0] K_STUR = 11'b11111000000;
   localparam logic [9:0]  K_ADDI = 10'b1001000100;
   localparam logic [9:0]  K_SUBI = 10'b1101000100;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic [63:0] MEM_DATA_IN;
   logic [63:0] PC;
   logic [63:0] MEM_ADDRESS;
   logic [63:0] MEM_DATA_OUT;
   logic        MEM_WRITE;
   logic        MEM_READ;

   legv8_cpu #(.RESET_PC(RESET_PC)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .INSTRUCTION  (INSTRUCTION),
      .MEM_DATA_IN  (MEM_DATA_IN),
      .PC           (PC),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_DATA_OUT (MEM_DATA_OUT),
      .MEM_WRITE    (MEM_WRITE),
      .MEM_READ     (MEM_READ)
   );

   always #5 CLOCK = ~CLOCK;

   int vectors     = 0;
   int miscompares = 0;

   // Architectural model state
   logic [63:0] m_pc;
   logic [63:0] m_x [0:31];
   logic [63:0] dmem [logic [63:0]];

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_read(input logic [63:0] a);
      if (dmem.exists(a)) return dmem[a];
      return {~a[31:0], a[31:0] ^ 32'h5A5A_C3C3};
   endfunction

   function automatic logic [63:0] xr(input logic [4:0] r);
      return (r == 5'd31) ? 64'd0 : m_x[r];
   endfunction

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'd0, rn, rd};
   endfunction

   function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
      return {op, imm, rn, rd};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] dt, input logic [4:0] rn, input logic [4:0] rt);
      return {op, dt, 2'b00, rn, rt};
   endfunction

   function automatic logic [31:0] enc_cb(input logic [18:0] imm, input logic [4:0] rt);
      return {8'b10110100, imm, rt};
   endfunction

   function automatic logic [31:0] enc_b(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   function automatic string mnemonic(input logic [31:0] instr);
      case (instr[31:21])
         K_ADD:  return "ADD";
         K_SUB:  return "SUB";
         K_AND:  return "AND";
         K_ORR:  return "ORR";
         K_LDUR: return "LDUR";
         K_STUR: return "STUR";
         default: ;
      endcase
      if (instr[31:22] == K_ADDI) return "ADDI";
      if (instr[31:22] == K_SUBI) return "SUBI";
      if (instr[31:24] == 8'b10110100) return "CBZ";
      if (instr[31:26] == 6'b000101) return "B";
      return "NOP";
   endfunction

   // One instruction per call: drive, check outputs mid-cycle, then retire into the model
   task automatic apply(input logic [31:0] instr, input logic rst);
      string       m;
      logic [63:0] n, mv, t, imm, off9, off19, off26;
      logic [63:0] npc, wval, exp_addr, exp_portb;
      logic        we, ld, st, addr_valid;
      logic [4:0]  rd_i;

      @(negedge CLOCK);
      INSTRUCTION = instr;
      RESET       = rst;
      #1;
      MEM_DATA_IN = mem_read(MEM_ADDRESS);
      #1;

      m     = mnemonic(instr);
      rd_i  = instr[4:0];
      n     = xr(instr[9:5]);
      mv    = xr(instr[20:16]);
      t     = xr(instr[4:0]);
      imm   = {52'd0, instr[21:10]};
      off9  = 64'($signed(instr[20:12]));
      off19 = 64'($signed(instr[23:5])) << 2;
      off26 = 64'($signed(instr[25:0])) << 2;
      npc   = m_pc + 64'd4;
      wval  = '0;
      exp_addr = '0;
      we = 1'b0; ld = 1'b0; st = 1'b0; addr_valid = 1'b1;
      exp_portb = (m == "STUR" || m == "CBZ") ? t : mv;

      case (m)
         "ADD":  begin wval = n + mv;  we = 1'b1; exp_addr = wval; end
         "SUB":  begin wval = n - mv;  we = 1'b1; exp_addr = wval; end
         "AND":  begin wval = n & mv;  we = 1'b1; exp_addr = wval; end
         "ORR":  begin wval = n | mv;  we = 1'b1; exp_addr = wval; end
         "ADDI": begin wval = n + imm; we = 1'b1; exp_addr = wval; end
         "SUBI": begin wval = n - imm; we = 1'b1; exp_addr = wval; end
         "LDUR": begin exp_addr = n + off9; ld = 1'b1; we = 1'b1; wval = mem_read(exp_addr); end
         "STUR": begin exp_addr = n + off9; st = 1'b1; end
         "CBZ":  begin addr_valid = 1'b0; if (t == 64'd0) npc = m_pc + off19; end
         "B":    begin addr_valid = 1'b0; npc = m_pc + off26; end
         default: addr_valid = 1'b0;
      endcase
      if (rst) begin
         ld = 1'b0;
         st = 1'b0;
      end

      $display("pc=%h instr=%h rst=%0d %s addr=%h", m_pc, instr, rst, m, MEM_ADDRESS);
      check_value({m, " pc"}, PC, m_pc);
      check_value({m, " mem_write"}, 64'(MEM_WRITE), 64'(st));
      check_value({m, " mem_read"}, 64'(MEM_READ), 64'(ld));
      check_value({m, " data_out"}, MEM_DATA_OUT, exp_portb);
      if (addr_valid) check_value({m, " address"}, MEM_ADDRESS, exp_addr);

      @(posedge CLOCK);
      if (rst) begin
         m_pc = RESET_PC;
         for (int i = 0; i < 32; i++) m_x[i] = '0;
      end else begin
         m_pc = npc;
         if (we && rd_i != 5'd31) m_x[rd_i] = wval;
         if (st) dmem[exp_addr] = t;
      end
   endtask

   // ORR XZR, Xk, XZR exposes Xk on MEM_ADDRESS without changing state
   task automatic dump_regs();
      for (int k = 0; k < 32; k++) apply(enc_r(K_ORR, 5'd31, 5'(k), 5'd31), 1'b0);
   endtask

   function automatic logic [4:0] rsel();
      return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [31:0] rand_instr();
      int off;
      off = int'($urandom_range(0, 15)) - 8;
      case ($urandom_range(0, 10))
         0: return enc_r(K_ADD, rsel(), rsel(), rsel());
         1: return enc_r(K_SUB, rsel(), rsel(), rsel());
         2: return enc_r(K_AND, rsel(), rsel(), rsel());
         3: return enc_r(K_ORR, rsel(), rsel(), rsel());
         4: return enc_i(K_ADDI, 12'($urandom_range(0, 4095)), rsel(), rsel());
         5: return enc_i(K_SUBI, 12'($urandom_range(0, 4095)), rsel(), rsel());
         6: return enc_d(K_LDUR, 9'($urandom_range(0, 511)), rsel(), rsel());
         7: return enc_d(K_STUR, 9'($urandom_range(0, 511)), rsel(), rsel());
         8: return enc_cb(off[18:0], rsel());
         9: return enc_b(off[25:0]);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      RESET       = 1'b1;
      INSTRUCTION = 32'd0;
      MEM_DATA_IN = 64'd0;
      repeat (2) @(posedge CLOCK);
      m_pc = RESET_PC;
      for (int i = 0; i < 32; i++) m_x[i] = '0;

      // Reset with a store presented: strobes must stay low, then NOPs step the PC
      apply(enc_d(K_STUR, 9'd8, 5'd1, 5'd2), 1'b1);
      for (int i = 0; i < 3; i++) apply(32'd0, 1'b0);

      // Immediate and register arithmetic, plus a discarded XZR write
      apply(enc_i(K_ADDI, 12'd5, 5'd31, 5'd1), 1'b0);
      apply(enc_i(K_ADDI, 12'd3, 5'd31, 5'd2), 1'b0);
      apply(enc_r(K_SUB, 5'd2, 5'd1, 5'd3), 1'b0);
      apply(enc_r(K_ADD, 5'd2, 5'd1, 5'd4), 1'b0);
      apply(enc_r(K_AND, 5'd2, 5'd1, 5'd5), 1'b0);
      apply(enc_r(K_ORR, 5'd2, 5'd1, 5'd6), 1'b0);
      apply(enc_i(K_ADDI, 12'd9, 5'd1, 5'd31), 1'b0);
      apply(enc_i(K_SUBI, 12'd6, 5'd1, 5'd10), 1'b0);
      dump_regs();

      // Store/load round trip, positive and negative displacement
      apply(enc_i(K_ADDI, 12'd16, 5'd31, 5'd1), 1'b0);
      apply(enc_i(K_ADDI, 12'h91A, 5'd31, 5'd2), 1'b0);
      apply(enc_r(K_ADD, 5'd2, 5'd2, 5'd2), 1'b0);
      apply(enc_d(K_STUR, 9'd8, 5'd1, 5'd2), 1'b0);
      apply(enc_d(K_LDUR, 9'd8, 5'd1, 5'd7), 1'b0);
      apply(enc_d(K_STUR, 9'h1F8, 5'd1, 5'd2), 1'b0);
      apply(enc_d(K_LDUR, 9'h1F8, 5'd1, 5'd8), 1'b0);
      dump_regs();

      // CBZ taken forward/backward and not taken
      apply(32'd0, 1'b1);
      for (int i = 0; i < 3; i++) apply(32'd0, 1'b0);
      apply(enc_cb(19'd3, 5'd9), 1'b0);
      apply(enc_cb(19'h7FFFE, 5'd9), 1'b0);
      apply(enc_i(K_ADDI, 12'd1, 5'd31, 5'd9), 1'b0);
      apply(enc_cb(19'd3, 5'd9), 1'b0);
      apply(32'd0, 1'b0);

      // Unconditional branches
      apply(32'd0, 1'b1);
      for (int i = 0; i < 2; i++) apply(32'd0, 1'b0);
      apply(enc_b(26'h3FFFFFE), 1'b0);
      for (int i = 0; i < 2; i++) apply(32'd0, 1'b0);
      apply(enc_b(26'd4), 1'b0);

      // Illegal encoding and a write presented during reset
      apply(enc_i(K_ADDI, 12'd42, 5'd31, 5'd3), 1'b0);
      apply(32'hFFFF_FFFF, 1'b0);
      dump_regs();
      apply(enc_i(K_ADDI, 12'd77, 5'd31, 5'd1), 1'b1);
      dump_regs();

      // Random program with occasional mid-stream reset
      for (int i = 0; i < 1500; i++) apply(rand_instr(), ($urandom_range(0, 99) == 0));
      dump_regs();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/legv8_cpu.md
Name: legv8_cpu

Overview:
- Single-cycle 64-bit LEGv8 integer core: fetches one 32-bit instruction per clock, executes it, and updates the PC on the rising edge.
- Instruction memory and data memory are external combinational blocks: the core drives PC and sees the instruction in the same cycle; the core drives address/data/strobes and sees read data in the same cycle.
- Contains PC register, 32x64 register file, decoder, ALU, branch logic.

Parameters:
- RESET_PC, 64'd0, PC value loaded by reset.

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- INSTRUCTION  input  32  instruction at address PC, combinational from external memory.
- MEM_DATA_IN  input  64  data memory read data, combinational from MEM_ADDRESS when MEM_READ=1.
- PC  output  64  current program counter (registered).
- MEM_ADDRESS  output  64  data memory byte address (ALU result).
- MEM_DATA_OUT  output  64  store data (register Rt).
- MEM_WRITE  output  1  store strobe, level-valid for the whole cycle.
- MEM_READ  output  1  load strobe.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. While RESET=1 at a rising edge: PC<=RESET_PC; X0..X30<=0. While RESET=1, MEM_WRITE and MEM_READ are forced to 0 and register write is suppressed.
- Fields:
  - Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16].
  - imm12=[21:10], dt9=[20:12], imm19=[23:5], imm26=[25:0].
- Register file:
  - 2 combinational read ports, 1 write port on the rising edge.
  - X31 (XZR) always reads 0; writes to X31 are discarded.
- Read port B: selects Rt for STUR/CBZ (Reg2Loc), otherwise Rm.
- Decode priority: 11-bit opcode [31:21], then 10-bit [31:22], then 8-bit [31:24], then 6-bit [31:26]. Supported instructions:
  - ADD 10001011000: Rd=Rn+Rm.
  - SUB 11001011000: Rd=Rn-Rm.
  - AND 10001010000: Rd=Rn&Rm.
  - ORR 10101010000: Rd=Rn|Rm.
  - ADDI 1001000100: Rd=Rn+ZeroExt(imm12).
  - SUBI 1101000100: Rd=Rn-ZeroExt(imm12).
  - LDUR 11111000010: Rt=MEM_DATA_IN, MEM_ADDRESS=Rn+SignExt(dt9), MEM_READ=1.
  - STUR 11111000000: MEM_ADDRESS=Rn+SignExt(dt9), MEM_DATA_OUT=Rt, MEM_WRITE=1.
  - CBZ 10110100: if Rt==0 then PC<=PC+(SignExt(imm19)<<2), else PC+4.
  - B 000101: PC<=PC+(SignExt(imm26)<<2).
- Any other encoding is a NOP: PC+4, no register write, MEM_WRITE=MEM_READ=0.
- Arithmetic: 64-bit modulo 2^64, no flags, no overflow detection.
- Branch target: PC of the branch instruction itself plus the shifted offset. Negative offsets wrap modulo 2^64.
- Outputs:
  - MEM_ADDRESS is the ALU result for every instruction.
  - MEM_DATA_OUT is always read port B.
  - Both strobes are 0 except for LDUR/STUR respectively.
- Timing: latency is 1 cycle per instruction.
  - Register and PC updates take effect at the next rising edge.
  - The external data memory is unclocked, so MEM_WRITE, MEM_ADDRESS and MEM_DATA_OUT are functions only of registered state and INSTRUCTION. They are stable for the cycle once settled.
- Write-before-read: none within a cycle. A register written by instruction N is visible to instruction N+1.
- Reset mid-program: the next edge with RESET=1 discards any in-flight write. The PC returns to RESET_PC and the registers clear.

Test Plan:
- Reset: hold RESET 1 cycle -> PC=0, MEM_WRITE=0, MEM_READ=0; after release PC increments 0,4,8 on successive NOP (0x00000000) edges.
- Immediate/R-type:
  - ADDI X1,XZR,#5; ADDI X2,XZR,#3; SUB X3,X1,X2; ADD X4,X1,X2; AND X5,X1,X2; ORR X6,X1,X2.
  - Expect MEM_ADDRESS 2, 8, 1, 7 for SUB/ADD/AND/ORR (SUB result 2, ORR result 7).
  - Writes to XZR read back 0.
- Memory:
  - X1=16, X2=0x1234; STUR X2,[X1,#8] -> MEM_ADDRESS=24, MEM_DATA_OUT=0x1234, MEM_WRITE=1.
  - Then LDUR X7,[X1,#8] -> MEM_READ=1; X7=0x1234 next cycle.
  - Negative dt9 = -8 -> address 8.
- CBZ:
  - At PC=12, CBZ X9(=0),#3 -> PC=24.
  - With X9=1 -> PC=16.
  - At PC=24, imm19=-2 -> PC=16.
- B:
  - At PC=8, B #-2 -> PC=0.
  - B #4 -> PC=24.
  - No register or memory side effects.
- Illegal opcode 0xFFFFFFFF -> PC+4, all strobes 0, register file unchanged.
